// File: rtl/result_router.sv
// result_router: buffers ALU results in a small FIFO and steers each entry to
// exactly one destination lane (GPR, PC, RAM, or user lanes) selected one-hot.
// Illegal selects are consumed and counted instead of stored.
module result_router #(
    parameter int WIDTH = 32,
    parameter int NDEST = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [NDEST-1:0]         in_sel,
    output logic [NDEST-1:0]         out_valid,
    input  logic [NDEST-1:0]         out_ready,
    output logic [NDEST*WIDTH-1:0]   out_data,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     sel_err,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NDEST-1:0] sel_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             ready_en;

    logic             accept;
    logic             sel_legal;
    logic             push;
    logic             drop;
    logic             pop;
    logic             not_empty;
    logic [NDEST-1:0] head_sel;
    logic [WIDTH-1:0] head_data;

    // Handshake decode: in_ready never looks at out_ready, so a full buffer
    // cannot pass a result straight through.
    assign not_empty = (count != '0);
    assign in_ready  = ready_en && (count < CW'(DEPTH)) && !flush;
    assign accept    = in_valid && in_ready;
    assign sel_legal = $onehot(in_sel);
    assign push      = accept && sel_legal;
    assign drop      = accept && !sel_legal;
    assign head_sel  = sel_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign out_valid = not_empty ? head_sel : '0;
    assign pop       = |(out_valid & out_ready);

    // Gate in_ready low during reset and until the first edge after release.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; stale contents are harmless because count gates the output.
    // NOTE: the storage array is deliberately not reset -- occupancy decides
    // what is visible, and leaving it out keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wr_ptr]  <= in_sel;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Sticky select error and saturating drop counter; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)         sel_err <= 1'b1;
            else if (err_clr) sel_err <= 1'b0;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Lane data: only the selected lane carries the head, all others read zero.
    // NOTE: out_data gets a full default before the loop so no bit can hold
    // its previous value and infer a latch.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NDEST; k++) begin
            if (out_valid[k]) out_data[k*WIDTH +: WIDTH] = head_data;
        end
    end

endmodule
